// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-digit counter and its digit cells.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_MIN   = 4'd0;
    localparam logic       MODE_UP   = 1'b1;
    localparam logic       MODE_DOWN = 1'b0;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the ripple chain: moves by one when cin is set, cout signals carry/borrow.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       inc,
    input  logic       dec,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);

    always_comb begin
        nxt  = digit;
        cout = 1'b0;
        if (cin && inc) begin
            if (digit >= BCD_MAX) begin
                nxt  = BCD_MIN;
                cout = 1'b1;
            end else begin
                nxt = digit + 4'd1;
            end
        end else if (cin && dec) begin
            if (digit == BCD_MIN) begin
                nxt  = BCD_MAX;
                cout = 1'b1;
            end else begin
                nxt = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_multi_digit_counter.sv
// N-digit BCD up/down counter with runtime limits, wrap/saturate policy and clamped load.
module bcd_multi_digit_counter
    import bcd_pkg::*;
#(
    parameter int                    DIGITS      = 2,
    parameter logic [4*DIGITS-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  step,
    input  logic                  mode_up,
    input  logic                  wrap_en,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [4*DIGITS-1:0]   upper_limit,
    input  logic [4*DIGITS-1:0]   lower_limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  at_top,
    output logic                  at_bottom,
    output logic                  wrap_pulse,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic          up;
    logic [W-1:0]  stepped;
    logic [W-1:0]  loaded;
    logic          clamped;
    logic [DIGITS-1:0] carry;
    logic          unused_cout;

    assign up        = (mode_up == MODE_UP);
    assign at_top    = (count >= upper_limit);
    assign at_bottom = (count <= lower_limit);
    assign carry[0]  = 1'b1;

    // Ripple chain: digit 0 always moves, higher digits move on carry/borrow.
    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        if (g < DIGITS - 1) begin : g_mid
            bcd_digit_cell u_cell (
                .digit (count[4*g +: 4]),
                .inc   (up),
                .dec   (mode_up == MODE_DOWN),
                .cin   (carry[g]),
                .nxt   (stepped[4*g +: 4]),
                .cout  (carry[g+1])
            );
        end else begin : g_last
            bcd_digit_cell u_cell (
                .digit (count[4*g +: 4]),
                .inc   (up),
                .dec   (mode_up == MODE_DOWN),
                .cin   (carry[g]),
                .nxt   (stepped[4*g +: 4]),
                .cout  (unused_cout)
            );
        end
    end

    always_comb begin
        loaded  = '0;
        clamped = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            loaded[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
            if (load_value[4*i +: 4] > BCD_MAX) clamped = 1'b1;
        end
    end

    // Priority: clear > load > step; clear/load act regardless of en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= RESET_VALUE;
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
            if (clear) begin
                count <= up ? lower_limit : upper_limit;
            end else if (load) begin
                count    <= loaded;
                load_err <= clamped;
            end else if (en && step) begin
                if (up) begin
                    if (at_top) begin
                        if (wrap_en) begin
                            count      <= lower_limit;
                            wrap_pulse <= 1'b1;
                        end
                    end else begin
                        count <= stepped;
                    end
                end else begin
                    if (at_bottom) begin
                        if (wrap_en) begin
                            count      <= upper_limit;
                            wrap_pulse <= 1'b1;
                        end
                    end else begin
                        count <= stepped;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_multi_digit_counter.sv
// Directed bench: a 2-digit counter driven from a vector table plus a 4-digit ripple check.
module tb_bcd_multi_digit_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, step, mode_up, wrap_en, clear, load;
    logic [7:0] load_value, upper_limit, lower_limit, count;
    logic       at_top, at_bottom, wrap_pulse, load_err;

    logic        en4, step4, mode_up4, wrap_en4, clear4, load4;
    logic [15:0] load_value4, upper_limit4, lower_limit4, count4;
    logic        at_top4, at_bottom4, wrap_pulse4, load_err4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_multi_digit_counter #(.DIGITS(2), .RESET_VALUE(8'h12)) dut (
        .clk(clk), .reset(reset), .en(en), .step(step), .mode_up(mode_up),
        .wrap_en(wrap_en), .clear(clear), .load(load), .load_value(load_value),
        .upper_limit(upper_limit), .lower_limit(lower_limit), .count(count),
        .at_top(at_top), .at_bottom(at_bottom), .wrap_pulse(wrap_pulse), .load_err(load_err)
    );

    bcd_multi_digit_counter #(.DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .step(step4), .mode_up(mode_up4),
        .wrap_en(wrap_en4), .clear(clear4), .load(load4), .load_value(load_value4),
        .upper_limit(upper_limit4), .lower_limit(lower_limit4), .count(count4),
        .at_top(at_top4), .at_bottom(at_bottom4), .wrap_pulse(wrap_pulse4), .load_err(load_err4)
    );

    typedef struct packed {
        logic       clr;
        logic       ld;
        logic       en;
        logic       stp;
        logic       up;
        logic       wr;
        logic [7:0] lv;
        logic [7:0] e_cnt;
        logic       e_top;
        logic       e_bot;
        logic       e_wp;
        logic       e_le;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive2(input logic c, input logic l, input logic e, input logic s,
                          input logic u, input logic w, input logic [7:0] v);
        @(negedge clk);
        clear = c; load = l; en = e; step = s; mode_up = u; wrap_en = w; load_value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic l, input logic s, input logic u, input logic w,
                          input logic [15:0] v);
        @(negedge clk);
        load4 = l; step4 = s; mode_up4 = u; wrap_en4 = w; load_value4 = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {en, step, mode_up, wrap_en, clear, load} = 6'b001100;
        load_value = 8'h00; upper_limit = 8'h59; lower_limit = 8'h00;
        {en4, step4, mode_up4, wrap_en4, clear4, load4} = 6'b101100;
        load_value4 = 16'h0000; upper_limit4 = 16'h9999; lower_limit4 = 16'h0000;

        //          clr ld en stp up wr  lv      cnt   top bot wp le
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'h58, 8'h58, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 8'h00, 8'h59, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'h09, 8'h09, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 8'h00, 8'h10, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 1, 8'h00, 8'h09, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'hA3, 8'h93, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 1, 8'h00, 8'h93, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'h37, 8'h37, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 1, 1, 1, 8'h45, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'h25, 8'h25, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 1, 8'h00, 8'h59, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'h3F, 8'h39, 0, 0, 0, 1});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0, 0, 0, 1, 1, 1, 8'h00, 8'h39, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 1, 8'h00, 8'h59, 1, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 1, 8'h00, 8'h58, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 0, 8'h59, 8'h59, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 0, 8'h00, 8'h59, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 8'hFF, 8'h99, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 0, 1, 8'h00, 8'h98, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 8'h00, 8'h00, 0, 1, 1, 0});

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        chk("rst_count", {8'h0, count}, 16'h0012);
        chk("rst_top", {15'h0, at_top}, 16'h0);
        chk("rst_bot", {15'h0, at_bottom}, 16'h0);
        chk("rst_wp", {15'h0, wrap_pulse}, 16'h0);
        chk("rst_le", {15'h0, load_err}, 16'h0);
        chk("rst_count4", count4, 16'h0000);
        chk("rst_bot4", {15'h0, at_bottom4}, 16'h1);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive2(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].stp,
                   vecs[i].up, vecs[i].wr, vecs[i].lv);
            chk($sformatf("v%0d_count", i), {8'h0, count}, {8'h0, vecs[i].e_cnt});
            chk($sformatf("v%0d_top", i), {15'h0, at_top}, {15'h0, vecs[i].e_top});
            chk($sformatf("v%0d_bot", i), {15'h0, at_bottom}, {15'h0, vecs[i].e_bot});
            chk($sformatf("v%0d_wrap", i), {15'h0, wrap_pulse}, {15'h0, vecs[i].e_wp});
            chk($sformatf("v%0d_lerr", i), {15'h0, load_err}, {15'h0, vecs[i].e_le});
        end

        // Async reset mid-cycle at 8'h37 takes effect without a clock edge
        drive2(0, 1, 1, 0, 1, 1, 8'h37);
        chk("pre_rst_count", {8'h0, count}, 16'h0037);
        @(negedge clk);
        load = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count", {8'h0, count}, 16'h0012);
        chk("async_rst_wp", {15'h0, wrap_pulse}, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset while a wrap pulse is showing clears it immediately
        drive2(0, 1, 1, 0, 1, 1, 8'h59);
        drive2(0, 0, 1, 1, 1, 1, 8'h00);
        chk("wrap_before_rst", {15'h0, wrap_pulse}, 16'h1);
        #2 reset = 1'b0;
        #1;
        chk("wrap_rst_wp", {15'h0, wrap_pulse}, 16'h0);
        chk("wrap_rst_count", {8'h0, count}, 16'h0012);
        @(negedge clk);
        reset = 1'b1;
        step = 1'b0;

        // Four-digit ripple carry and borrow across three digits
        drive4(1, 0, 1, 1, 16'h0999);
        chk("d4_load", count4, 16'h0999);
        drive4(0, 1, 1, 1, 16'h0000);
        chk("d4_carry", count4, 16'h1000);
        drive4(0, 1, 0, 1, 16'h0000);
        chk("d4_borrow", count4, 16'h0999);
        drive4(1, 0, 1, 1, 16'h9999);
        chk("d4_top", {15'h0, at_top4}, 16'h1);
        drive4(0, 1, 1, 1, 16'h0000);
        chk("d4_wrap_count", count4, 16'h0000);
        chk("d4_wrap_pulse", {15'h0, wrap_pulse4}, 16'h1);
        drive4(1, 0, 1, 1, 16'h9A0C);
        chk("d4_clamp", count4, 16'h9909);
        chk("d4_lerr", {15'h0, load_err4}, 16'h1);
        drive4(0, 0, 1, 1, 16'h0000);
        chk("d4_lerr_clear", {15'h0, load_err4}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
